// File: rtl/cache_control.sv
// rtl/cache_control.sv - two-way set-associative cache controller FSM with hit/miss counters
//
// Ports:
//   clk, rst_n                   clock; asynchronous active-low reset
//   mem_read, mem_write          CPU request, held until mem_resp (write wins if both)
//   hit0, hit1                   tag match + valid for way 0 / way 1 of the current set
//   lru_bit, victim_dirty        LRU way of the set and the dirty bit of that way
//   pmem_resp                    one-cycle completion pulse from physical memory
//   mem_resp                     CPU access complete
//   pmem_read, pmem_write        physical memory line read / write request
//   pmem_addr_sel                0 = CPU line address, 1 = victim tag address
//   lru_or_way, way_sel          load arbitrator steering (0 = lru_bit, 1 = way_sel)
//   load_data/tag/valid          array loads for the arbitrated way
//   set_dirty, clear_dirty       dirty-bit update for the arbitrated way
//   load_lru, lru_in             LRU update; lru_in is the way not just used
//   hit_count, miss_count        16-bit wrapping performance counters

module cache_control (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic        hit0,
   input  logic        hit1,
   input  logic        lru_bit,
   input  logic        victim_dirty,
   input  logic        pmem_resp,
   output logic        mem_resp,
   output logic        pmem_read,
   output logic        pmem_write,
   output logic        pmem_addr_sel,
   output logic        lru_or_way,
   output logic        way_sel,
   output logic        load_data,
   output logic        load_tag,
   output logic        load_valid,
   output logic        set_dirty,
   output logic        clear_dirty,
   output logic        load_lru,
   output logic        lru_in,
   output logic [15:0] hit_count,
   output logic [15:0] miss_count
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_HITMISS   = 2'd1,
      S_WRITEBACK = 2'd2,
      S_FILL      = 2'd3
   } state_t;

   state_t state;
   logic   miss_pending;
   logic   req;
   logic   is_write;
   logic   hit;

   assign req      = mem_read | mem_write;
   assign is_write = mem_write;
   assign hit      = hit0 | hit1;

   // lru_bit only matters to the external load arbitrator; the FSM never looks at it.
   logic unused_lru_bit;
   assign unused_lru_bit = lru_bit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         miss_pending <= 1'b0;
         hit_count    <= 16'd0;
         miss_count   <= 16'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req) state <= S_HITMISS;
            end
            S_HITMISS: begin
               if (!req) begin
                  state        <= S_IDLE;
                  miss_pending <= 1'b0;
               end else if (hit) begin
                  // A hit while miss_pending is the retry after our own fill.
                  if (!miss_pending) hit_count <= hit_count + 16'd1;
                  state        <= S_IDLE;
                  miss_pending <= 1'b0;
               end else begin
                  if (!miss_pending) miss_count <= miss_count + 16'd1;
                  miss_pending <= 1'b1;
                  state        <= victim_dirty ? S_WRITEBACK : S_FILL;
               end
            end
            S_WRITEBACK: begin
               if (pmem_resp) state <= S_FILL;
            end
            S_FILL: begin
               if (pmem_resp) state <= S_HITMISS;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      mem_resp      = 1'b0;
      pmem_read     = 1'b0;
      pmem_write    = 1'b0;
      pmem_addr_sel = 1'b0;
      lru_or_way    = 1'b0;
      way_sel       = 1'b0;
      load_data     = 1'b0;
      load_tag      = 1'b0;
      load_valid    = 1'b0;
      set_dirty     = 1'b0;
      clear_dirty   = 1'b0;
      load_lru      = 1'b0;
      lru_in        = 1'b0;
      case (state)
         S_HITMISS: begin
            if (req && hit) begin
               mem_resp   = 1'b1;
               load_lru   = 1'b1;
               lru_or_way = 1'b1;
               // way 1 wins if both hits are (illegally) asserted
               way_sel    = hit1;
               lru_in     = ~hit1;
               if (is_write) begin
                  load_data = 1'b1;
                  set_dirty = 1'b1;
               end
            end
         end
         S_WRITEBACK: begin
            pmem_write    = 1'b1;
            pmem_addr_sel = 1'b1;
         end
         S_FILL: begin
            pmem_read = 1'b1;
            if (pmem_resp) begin
               load_data   = 1'b1;
               load_tag    = 1'b1;
               load_valid  = 1'b1;
               clear_dirty = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cache_control.sv
// tb/tb_cache_control.sv - directed table-driven bench for cache_control

module tb_cache_control;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_read, mem_write, hit0, hit1, lru_bit, victim_dirty, pmem_resp;
   logic        mem_resp, pmem_read, pmem_write, pmem_addr_sel, lru_or_way, way_sel;
   logic        load_data, load_tag, load_valid, set_dirty, clear_dirty, load_lru, lru_in;
   logic [15:0] hit_count, miss_count;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   cache_control dut (
      .clk(clk), .rst_n(rst_n),
      .mem_read(mem_read), .mem_write(mem_write),
      .hit0(hit0), .hit1(hit1), .lru_bit(lru_bit), .victim_dirty(victim_dirty),
      .pmem_resp(pmem_resp),
      .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_addr_sel(pmem_addr_sel), .lru_or_way(lru_or_way), .way_sel(way_sel),
      .load_data(load_data), .load_tag(load_tag), .load_valid(load_valid),
      .set_dirty(set_dirty), .clear_dirty(clear_dirty),
      .load_lru(load_lru), .lru_in(lru_in),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   // Output bit order: mem_resp pmem_read pmem_write pmem_addr_sel lru_or_way way_sel
   //                   load_data load_tag load_valid set_dirty clear_dirty load_lru lru_in
   typedef struct {
      logic        rd, wr, h0, h1, vd, presp;
      logic [12:0] exp;
      logic [15:0] hc, mc;
   } vec_t;

   localparam logic [12:0] O_NONE  = 13'b0_0_0_0_0_0_0_0_0_0_0_0_0;
   localparam logic [12:0] O_RHIT0 = 13'b1_0_0_0_1_0_0_0_0_0_0_1_1;
   localparam logic [12:0] O_RHIT1 = 13'b1_0_0_0_1_1_0_0_0_0_0_1_0;
   localparam logic [12:0] O_WHIT0 = 13'b1_0_0_0_1_0_1_0_0_1_0_1_1;
   localparam logic [12:0] O_WHIT1 = 13'b1_0_0_0_1_1_1_0_0_1_0_1_0;
   localparam logic [12:0] O_FILL  = 13'b0_1_0_0_0_0_0_0_0_0_0_0_0;
   localparam logic [12:0] O_FLOAD = 13'b0_1_0_0_0_0_1_1_1_0_1_0_0;
   localparam logic [12:0] O_WB    = 13'b0_0_1_1_0_0_0_0_0_0_0_0_0;

   vec_t vecs[33];

   function automatic vec_t mk(input logic rd, wr, h0, h1, vd, presp,
                               input logic [12:0] exp, input logic [15:0] hc, mc);
      vec_t v;
      v.rd = rd; v.wr = wr; v.h0 = h0; v.h1 = h1; v.vd = vd; v.presp = presp;
      v.exp = exp; v.hc = hc; v.mc = mc;
      return v;
   endfunction

   function automatic logic [12:0] outs();
      return {mem_resp, pmem_read, pmem_write, pmem_addr_sel, lru_or_way, way_sel,
              load_data, load_tag, load_valid, set_dirty, clear_dirty, load_lru, lru_in};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock cycle: inputs applied just after the rising edge, outputs checked at the falling edge.
   task automatic cyc(input logic rd, wr, h0, h1, vd, presp);
      @(posedge clk);
      #1;
      mem_read = rd; mem_write = wr; hit0 = h0; hit1 = h1;
      victim_dirty = vd; pmem_resp = presp;
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      mem_read = 0; mem_write = 0; hit0 = 0; hit1 = 0; victim_dirty = 0; pmem_resp = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      //               rd wr h0 h1 vd pr  outputs   hc     mc
      vecs[0]  = mk(0, 0, 0, 0, 0, 0, O_NONE,  16'd0, 16'd0);
      vecs[1]  = mk(1, 0, 1, 0, 0, 0, O_NONE,  16'd0, 16'd0);
      vecs[2]  = mk(1, 0, 1, 0, 0, 0, O_RHIT0, 16'd0, 16'd0);
      vecs[3]  = mk(0, 0, 0, 0, 0, 0, O_NONE,  16'd1, 16'd0);
      vecs[4]  = mk(0, 1, 0, 1, 0, 0, O_NONE,  16'd1, 16'd0);
      vecs[5]  = mk(0, 1, 0, 1, 0, 0, O_WHIT1, 16'd1, 16'd0);
      vecs[6]  = mk(1, 1, 1, 0, 0, 0, O_NONE,  16'd2, 16'd0);
      vecs[7]  = mk(1, 1, 1, 0, 0, 0, O_WHIT0, 16'd2, 16'd0);
      vecs[8]  = mk(1, 0, 1, 1, 0, 0, O_NONE,  16'd3, 16'd0);
      vecs[9]  = mk(1, 0, 1, 1, 0, 0, O_RHIT1, 16'd3, 16'd0);
      // clean read miss, memory answers on the third fill cycle
      vecs[10] = mk(1, 0, 0, 0, 0, 0, O_NONE,  16'd4, 16'd0);
      vecs[11] = mk(1, 0, 0, 0, 0, 0, O_NONE,  16'd4, 16'd0);
      vecs[12] = mk(1, 0, 0, 0, 0, 0, O_FILL,  16'd4, 16'd1);
      vecs[13] = mk(1, 0, 0, 0, 0, 0, O_FILL,  16'd4, 16'd1);
      vecs[14] = mk(1, 0, 0, 0, 0, 1, O_FLOAD, 16'd4, 16'd1);
      vecs[15] = mk(1, 0, 1, 0, 0, 0, O_RHIT0, 16'd4, 16'd1);
      vecs[16] = mk(0, 0, 0, 0, 0, 0, O_NONE,  16'd4, 16'd1);
      // dirty write miss: writeback, fill, retry hit in way 1
      vecs[17] = mk(0, 1, 0, 0, 1, 0, O_NONE,  16'd4, 16'd1);
      vecs[18] = mk(0, 1, 0, 0, 1, 0, O_NONE,  16'd4, 16'd1);
      vecs[19] = mk(0, 1, 0, 0, 1, 0, O_WB,    16'd4, 16'd2);
      vecs[20] = mk(0, 1, 0, 0, 1, 1, O_WB,    16'd4, 16'd2);
      vecs[21] = mk(0, 1, 0, 0, 0, 0, O_FILL,  16'd4, 16'd2);
      vecs[22] = mk(0, 1, 0, 0, 0, 1, O_FLOAD, 16'd4, 16'd2);
      vecs[23] = mk(0, 1, 0, 1, 0, 0, O_WHIT1, 16'd4, 16'd2);
      vecs[24] = mk(0, 0, 0, 0, 0, 0, O_NONE,  16'd4, 16'd2);
      // request dropped during fill: pmem_read holds, then back to idle, pending cleared
      vecs[25] = mk(1, 0, 0, 0, 0, 0, O_NONE,  16'd4, 16'd2);
      vecs[26] = mk(1, 0, 0, 0, 0, 0, O_NONE,  16'd4, 16'd2);
      vecs[27] = mk(0, 0, 0, 0, 0, 0, O_FILL,  16'd4, 16'd3);
      vecs[28] = mk(0, 0, 0, 0, 0, 1, O_FLOAD, 16'd4, 16'd3);
      vecs[29] = mk(0, 0, 1, 0, 0, 0, O_NONE,  16'd4, 16'd3);
      vecs[30] = mk(1, 0, 1, 0, 0, 0, O_NONE,  16'd4, 16'd3);
      vecs[31] = mk(1, 0, 1, 0, 0, 0, O_RHIT0, 16'd4, 16'd3);
      vecs[32] = mk(0, 0, 0, 0, 0, 0, O_NONE,  16'd5, 16'd3);

      rst_n = 1'b0; lru_bit = 1'b0;
      mem_read = 0; mem_write = 0; hit0 = 0; hit1 = 0; victim_dirty = 0; pmem_resp = 0;
      @(negedge clk);
      @(negedge clk);
      check("reset_outs", 32'(outs()), 32'(O_NONE));
      check("reset_hit_count", 32'(hit_count), 32'd0);
      check("reset_miss_count", 32'(miss_count), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 33; i++) begin
         lru_bit = vecs[i].wr;
         cyc(vecs[i].rd, vecs[i].wr, vecs[i].h0, vecs[i].h1, vecs[i].vd, vecs[i].presp);
         check($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vecs[i].exp));
         check($sformatf("vec%0d_hit_count", i), 32'(hit_count), 32'(vecs[i].hc));
         check($sformatf("vec%0d_miss_count", i), 32'(miss_count), 32'(vecs[i].mc));
      end

      // reset in the middle of a fill
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      check("fill_before_reset", 32'(pmem_read), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("fill_reset_pmem_read", 32'(pmem_read), 32'd0);
      check("fill_reset_outs", 32'(outs()), 32'(O_NONE));
      check("fill_reset_hit_count", 32'(hit_count), 32'd0);
      check("fill_reset_miss_count", 32'(miss_count), 32'd0);
      cyc(1, 0, 1, 0, 0, 0);
      check("held_reset_outs", 32'(outs()), 32'(O_NONE));
      rst_n = 1'b1;
      // first edge after release leaves S_IDLE, so the hit completes one cycle later
      cyc(1, 0, 1, 0, 0, 0);
      check("post_reset_hit", 32'(outs()), 32'(O_RHIT0));
      cyc(0, 0, 0, 0, 0, 0);
      check("post_reset_hit_count", 32'(hit_count), 32'd1);

      // reset in the middle of a writeback
      cyc(0, 1, 0, 0, 1, 0);
      cyc(0, 1, 0, 0, 1, 0);
      cyc(0, 1, 0, 0, 1, 0);
      check("wb_before_reset", 32'(outs()), 32'(O_WB));
      #1 rst_n = 1'b0;
      #1;
      check("wb_reset_pmem_write", 32'(pmem_write), 32'd0);
      check("wb_reset_miss_count", 32'(miss_count), 32'd0);

      // hit counter wrap after 65535 hits
      do_reset();
      for (int n = 0; n < 65535; n++) begin
         cyc(1, 0, 1, 0, 0, 0);
         cyc(1, 0, 1, 0, 0, 0);
      end
      cyc(1, 0, 1, 0, 0, 0);
      check("wrap_preload", 32'(hit_count), 32'd65535);
      cyc(1, 0, 1, 0, 0, 0);
      check("wrap_last_hit", 32'(outs()), 32'(O_RHIT0));
      cyc(0, 0, 0, 0, 0, 0);
      check("wrap_hit_count", 32'(hit_count), 32'd0);
      check("wrap_miss_count", 32'(miss_count), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
